mips_muldiv_unit: RTL and testbench
===================================

Name: mips_muldiv_unit

Overview:
- Multi-cycle multiply/divide unit that owns the architectural HI/LO registers of the MIPS core.
- It sits beside the ALU in the execute stage.
- The decoder issues MULT/MULTU/DIV/DIVU, MTHI and MTLO to it.
- MFHI/MFLO read its hi/lo outputs directly.
- It replaces single-cycle combinational multiply/divide with a 32-iteration shift-add multiplier and restoring divider, and provides a busy/done handshake so the control FSM can stall.

Parameters:
- WIDTH, 32, operand and HI/LO width. Iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  launches an operation. Sampled only when busy=0.
- op  input  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV. Sampled with start.
- rs_data  input  WIDTH  multiplicand or dividend. Sampled with start, or with mthi/mtlo.
- rt_data  input  WIDTH  multiplier or divisor. Sampled with start.
- mthi  input  1  write rs_data to HI. Honoured only when busy=0.
- mtlo  input  1  write rs_data to LO. Honoured only when busy=0.
- hi  output  WIDTH  HI register (product upper half, or remainder).
- lo  output  WIDTH  LO register (product lower half, or quotient).
- busy  output  1  high while an operation is in flight. Control must stall MFHI/MFLO/start while busy.
- done  output  1  one-cycle pulse, high in the cycle hi/lo first show the new result.

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE; hi=0, lo=0, busy=0, done=0; internal accumulator, operand and count registers cleared. Reset asserted mid-operation aborts the operation and discards any partial result.
- States: IDLE, RUN, FIX.
- IDLE, start=1 at edge E0:
  - Latch op.
  - For signed ops, latch |rs|, |rt| and the sign flags; otherwise latch the raw operands.
  - count=0, busy<=1, next state RUN.
- RUN: one iteration per edge.
  - Multiply: conditional add of the multiplicand into the upper half of a 2*WIDTH accumulator, then a right shift.
  - Divide: shift the remainder left, trial-subtract the divisor, set the quotient bit if the result is non-negative.
  - After WIDTH iterations (edges E1..E32), state goes to FIX.
- FIX (edge E33):
  - Apply sign correction, then write hi/lo.
  - busy<=0, done<=1 for exactly one cycle, state goes to IDLE.
  - Fixed latency is 33 edges from the sampling edge to hi/lo valid.
- Signed rules:
  - MULT: negate the 64-bit product if sign(rs) XOR sign(rt).
  - DIV: quotient negated if the signs differ; remainder takes the sign of the dividend (truncation toward zero).
  - Most-negative operand: abs is taken as an unsigned WIDTH-bit value, giving correct 2's-complement results. 0x80000000 / 0xFFFFFFFF yields lo=0x80000000, hi=0.
- Divide by zero: no trap. Natural restoring result: lo=all ones, hi=dividend (unsigned magnitude, then DIV sign fixup rules applied). Full latency.
- start while busy: ignored. No queuing; busy stays high.
- mthi/mtlo:
  - When busy=0, HI or LO is written at the edge (both may be written in the same cycle). The result is visible next cycle.
  - When busy=1, they are ignored.
- start and mthi/mtlo in the same idle cycle: start wins and the move is dropped.
- done is never high while busy=1. hi/lo hold their values between writes.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- Defined: multiply ops leave RUN for FIX at the first edge on which the remaining (shifted) multiplier magnitude is zero. Latency from the sampling edge to result = 2 + (highest set bit index of |rt| + 1). A zero multiplier gives latency 2. Divide is unchanged at 33. Results are identical to the full-latency case.
- Undefined: all operations take fixed latency 33.

Test Plan:
- MULT rs=0xFFFFFFFD (-3), rt=5 -> done at edge 33: hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high for edges E0..E32.
- DIVU rs=100, rt=7 -> lo=14, hi=2. DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU rs=5, rt=0 -> lo=0xFFFFFFFF, hi=5, no hang. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI rs=0x1234 idle -> hi=0x1234 next cycle. Second start and mtlo during busy -> ignored, first result intact, single done pulse.
- Assert reset_n=0 at RUN edge 10 -> hi=lo=0, busy=0, done=0 immediately; a new MULTU 6*7 then gives lo=42, hi=0.
- With MULDIV_EARLY_OUT_EN: MULTU rs=9, rt=3 -> lo=27 after 4 edges. rt=0 -> lo=0 after 2 edges. DIVU still 33.

Source files
------------

// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit
//   Multi-cycle multiply/divide unit that owns the architectural HI/LO
//   registers. It uses a WIDTH-iteration shift-add multiplier and a
//   restoring divider. Signed operations run on magnitudes, and the sign is
//   fixed up in a final FIX cycle.
//
// Ports
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   start    : launch an operation (sampled only while idle)
//   op       : 00 MULTU, 01 MULT, 10 DIVU, 11 DIV (sampled with start)
//   rs_data  : multiplicand / dividend; also the MTHI/MTLO source
//   rt_data  : multiplier / divisor
//   mthi     : write rs_data to HI (idle only; start takes priority)
//   mtlo     : write rs_data to LO (idle only; start takes priority)
//   hi, lo   : HI/LO registers (product high/low, or remainder/quotient)
//   busy     : operation in flight
//   done     : one-cycle pulse in the first cycle hi/lo show a new result
//
// Optional feature: define MULDIV_EARLY_OUT_EN to let multiplies leave RUN
// as soon as the remaining multiplier magnitude is zero.
module mips_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             mthi,
  input  logic             mtlo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t state, state_n;

  logic [1:0]         op_r;
  logic               neg_q;     // negate product / quotient
  logic               neg_r;     // negate remainder (dividend sign)
  logic [2*WIDTH-1:0] acc;       // {upper/remainder, multiplier/quotient}
  logic [WIDTH-1:0]   opnd;      // multiplicand or divisor magnitude
  logic [CW-1:0]      count;
`ifdef MULDIV_EARLY_OUT_EN
  logic [WIDTH-1:0]   mplier;    // remaining multiplier bits
`endif

  logic launch, step, move_ok;

  // Operand magnitudes for launch
  logic             sign_rs, sign_rt;
  logic [WIDTH-1:0] abs_rs, abs_rt;

  always_comb begin
    sign_rs = op[0] & rs_data[WIDTH-1];
    sign_rt = op[0] & rt_data[WIDTH-1];
    abs_rs  = sign_rs ? ('0 - rs_data) : rs_data;
    abs_rt  = sign_rt ? ('0 - rt_data) : rt_data;
  end

  // Next state and control strobes
  always_comb begin
    state_n = state;
    launch  = 1'b0;
    step    = 1'b0;
    move_ok = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          launch  = 1'b1;
          state_n = RUN;
        end else begin
          move_ok = 1'b1;
        end
      end
      RUN: begin
`ifdef MULDIV_EARLY_OUT_EN
        // Multiplies exit only on an exhausted multiplier; this also covers
        // the full-width case one edge after the last iteration.
        if (!op_r[1] && mplier == '0) begin
          state_n = FIX;
        end else begin
          step = 1'b1;
          if (op_r[1] && count == CW'(WIDTH - 1)) state_n = FIX;
        end
`else
        step = 1'b1;
        if (count == CW'(WIDTH - 1)) state_n = FIX;
`endif
      end
      FIX:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  assign busy = (state != IDLE);

  // One iteration of multiply or divide
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] acc_step;

  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    rem_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff    = rem_sh - {1'b0, opnd};
    if (op_r[1]) begin
      if (diff[WIDTH]) acc_step = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else             acc_step = {diff[WIDTH-1:0],   acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  // Sign correction for the final write
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [2*WIDTH-1:0] result;

  always_comb begin
`ifdef MULDIV_EARLY_OUT_EN
    // After k iterations the product sits in the top WIDTH+k bits.
    prod = acc >> (CW'(WIDTH) - count);
`else
    prod = acc;
`endif
    prod_fix = neg_q ? ('0 - prod) : prod;
    quo_fix  = neg_q ? ('0 - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    rem_fix  = neg_r ? ('0 - acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
    result   = op_r[1] ? {rem_fix, quo_fix} : prod_fix;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_r   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      acc    <= '0;
      opnd   <= '0;
      count  <= '0;
`ifdef MULDIV_EARLY_OUT_EN
      mplier <= '0;
`endif
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= (state == FIX);
      if (launch) begin
        op_r  <= op;
        neg_q <= sign_rs ^ sign_rt;
        neg_r <= sign_rs;
        count <= '0;
        if (op[1]) begin
          opnd <= abs_rt;
          acc  <= {{WIDTH{1'b0}}, abs_rs};
        end else begin
          opnd <= abs_rs;
          acc  <= {{WIDTH{1'b0}}, abs_rt};
        end
`ifdef MULDIV_EARLY_OUT_EN
        mplier <= abs_rt;
`endif
      end
      if (step) begin
        acc   <= acc_step;
        count <= count + 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
        mplier <= mplier >> 1;
`endif
      end
      if (state == FIX) begin
        hi <= result[2*WIDTH-1:WIDTH];
        lo <= result[WIDTH-1:0];
      end else if (move_ok) begin
        if (mthi) hi <= rs_data;
        if (mtlo) lo <= rs_data;
      end
    end
  end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Testbench for mips_muldiv_unit: directed vector table, hand-written
// handshake/reset sequences, and random operations against an arithmetic
// reference model.
module tb_mips_muldiv_unit;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        mthi;
  logic        mtlo;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int n_pass  = 0;
  int n_total = 0;

  mips_muldiv_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .mthi    (mthi),
    .mtlo    (mtlo),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Reference result {hi, lo} from plain arithmetic
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint x, y, q, r;
    logic [63:0] p;
    case (o)
      2'd0: p = {32'd0, a} * {32'd0, b};
      2'd1: begin
        x = longint'(signed'(a));
        y = longint'(signed'(b));
        p = 64'(x * y);
      end
      2'd2: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else        p = {a % b, a / b};
      end
      default: begin
        x = longint'(signed'(a));
        if (b == 0) begin
          // magnitude quotient is all ones, remainder is |a|; then sign rules
          p = {a, (a[31] ? 32'd1 : 32'hFFFF_FFFF)};
        end else begin
          y = longint'(signed'(b));
          q = x / y;
          r = x % y;
          p = {r[31:0], q[31:0]};
        end
      end
    endcase
    return p;
  endfunction

  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] b);
    int lat;
    lat = 33;
`ifdef MULDIV_EARLY_OUT_EN
    if (!o[1]) begin
      logic [31:0] m;
      int bits;
      m = (o[0] && b[31]) ? (32'd0 - b) : b;
      bits = 0;
      for (int i = 0; i < 32; i++) if (m[i]) bits = i + 1;
      lat = 2 + bits;
    end
`endif
    return lat;
  endfunction

  // Count edges after the sampling edge until done, bounded.
  task automatic wait_done(output int n, output bit got, output bit busy_ok);
    n = 0; got = 1'b0; busy_ok = 1'b1;
    while (!got && n < 100) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      n++;
      if (done) got = 1'b1;
    end
  endtask

  task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh,
                        input logic [31:0] el, input int elat);
    int n;
    bit got, busy_ok;
    @(negedge clk);
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n, got, busy_ok);
    chk({nm, " latency"}, 64'(n), 64'(elat));
    chk({nm, " busy"}, 64'(busy_ok), 64'd1);
    chk({nm, " busy@done"}, 64'(busy), 64'd0);
    chk({nm, " hi"}, 64'(hi), 64'(eh));
    chk({nm, " lo"}, 64'(lo), 64'(el));
    @(posedge clk); #1;
    chk({nm, " done pulse"}, 64'(done), 64'd0);
  endtask

  task automatic move(input logic h, input logic l, input logic [31:0] v);
    @(negedge clk);
    mthi = h; mtlo = l; rs_data = v;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
  endtask

  vec_t vecs[9];
  logic [31:0] pool[8];

  initial begin
    int n, dn;
    bit got, busy_ok;
    logic [63:0] m;
    logic [1:0] o;
    logic [31:0] a, b;

    vecs[0] = '{"MULT -3*5",        2'd1, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[1] = '{"DIVU 100/7",       2'd2, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[2] = '{"DIV -7/2",         2'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{"DIVU 5/0",         2'd2, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
    vecs[4] = '{"DIV min/-1",       2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
    vecs[5] = '{"MULTU 9*3",        2'd0, 32'd9,         32'd3,         32'd0,         32'd27};
    vecs[6] = '{"MULTU x*0",        2'd0, 32'd12345,     32'd0,         32'd0,         32'd0};
    vecs[7] = '{"MULTU max*max",    2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1};
    vecs[8] = '{"MULT min*min",     2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};

    pool = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd7, 32'd3, 32'd100};

    reset_n = 1'b0; start = 1'b0; op = '0; rs_data = '0; rt_data = '0;
    mthi = 1'b0; mtlo = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].hi, vecs[i].lo,
             exp_lat(vecs[i].op, vecs[i].rt));

    // MTHI alone, then both moves together
    move(1'b1, 1'b0, 32'h0000_1234);
    chk("mthi hi", 64'(hi), 64'h1234);
    chk("mthi lo kept", 64'(lo), 64'd0);
    move(1'b1, 1'b1, 32'h0000_1111);
    chk("mthi+mtlo hi", 64'(hi), 64'h1111);
    chk("mthi+mtlo lo", 64'(lo), 64'h1111);

    // start together with moves: moves are dropped
    @(negedge clk);
    op = 2'd0; rs_data = 32'd6; rt_data = 32'h4000_0000; start = 1'b1; mthi = 1'b1; mtlo = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    chk("start wins hi", 64'(hi), 64'h1111);
    chk("start wins lo", 64'(lo), 64'h1111);
    chk("start wins busy", 64'(busy), 64'd1);
    // second start and moves while busy are ignored
    repeat (2) @(posedge clk);
    @(negedge clk);
    op = 2'd3; rs_data = 32'hDEAD; rt_data = 32'd3; start = 1'b1; mthi = 1'b1; mtlo = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    chk("busy move hi", 64'(hi), 64'h1111);
    wait_done(n, got, busy_ok);
    chk("busy ignore latency", 64'(n + 3), 64'(exp_lat(2'd0, 32'h4000_0000)));
    chk("busy ignore hi", 64'(hi), 64'd1);
    chk("busy ignore lo", 64'(lo), 64'h8000_0000);
    dn = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    chk("single done", 64'(dn), 64'd0);
    chk("idle after", 64'(busy), 64'd0);
    chk("result held lo", 64'(lo), 64'h8000_0000);

    // reset in the middle of RUN
    move(1'b1, 1'b1, 32'h0000_AAAA);
    @(negedge clk);
    op = 2'd0; rs_data = 32'd3; rt_data = 32'h4000_0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("abort hi", 64'(hi), 64'd0);
    chk("abort lo", 64'(lo), 64'd0);
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_op("MULTU 6*7 after reset", 2'd0, 32'd6, 32'd7, 32'd0, 32'd42, exp_lat(2'd0, 32'd7));

    // random operations against the model
    for (int k = 0; k < 40; k++) begin
      o = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 7)] : 32'($urandom);
      b = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 7)] : 32'($urandom);
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
      m = model(o, a, b);
      run_op($sformatf("rand%0d op%0d", k, o), o, a, b, m[63:32], m[31:0], exp_lat(o, b));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
